// File: rtl/pipe_dest_tracker.sv
// Destination-info shift chain (EX, MEM, WB, post-WB) feeding the forwarding unit.
// Inserts a MEM bubble on load stalls, kills EX entry on flush, and counts stall cycles.
module pipe_dest_tracker #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic              i_id_wren,
  input  logic              i_id_memtoreg,
  input  logic [ADDR_W-1:0] i_id_wraddr,
  input  logic              i_load_stall,
  input  logic              i_flush,
  output logic              o_front_hold,
  output logic              o_ex_wren,
  output logic              o_ex_memtoreg,
  output logic [ADDR_W-1:0] o_ex_wraddr,
  output logic              o_firstwren,
  output logic              o_nextMemtoReg,
  output logic [ADDR_W-1:0] o_firstWriteRegister,
  output logic              o_nextwren,
  output logic              o_MemtoReg,
  output logic [ADDR_W-1:0] o_nextWriteRegister,
  output logic              o_wren,
  output logic              o_prevMemtoReg,
  output logic [ADDR_W-1:0] o_writeRegister,
  output logic [CNT_W-1:0]  o_stall_count
);

  // Slot index: 0 = EX, 1 = MEM, 2 = WB, 3 = post-WB
  logic [3:0]        r_wren;
  logic [3:0]        r_mtr;
  logic [ADDR_W-1:0] r_addr [4];
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_addr_nz;
  logic              w_in_wren;
  logic              w_in_mtr;
  logic [ADDR_W-1:0] w_in_addr;

  // Writes to register 0 are architecturally dead, so they never reach the chain.
  assign w_addr_nz = |i_id_wraddr;
  assign w_in_wren = i_id_valid & i_id_wren & w_addr_nz;
  assign w_in_mtr  = i_id_valid & i_id_memtoreg & w_addr_nz;
  assign w_in_addr = i_id_valid ? i_id_wraddr : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wren        <= '0;
      r_mtr         <= '0;
      r_stall_count <= '0;
      for (int i = 0; i < 4; i++) r_addr[i] <= '0;
    end else begin
      r_wren[3] <= r_wren[2];
      r_mtr[3]  <= r_mtr[2];
      r_addr[3] <= r_addr[2];
      r_wren[2] <= r_wren[1];
      r_mtr[2]  <= r_mtr[1];
      r_addr[2] <= r_addr[1];
      if (i_load_stall) begin
        // EX holds its consumer; a bubble opens behind the load. Flush is ignored here.
        r_wren[1] <= 1'b0;
        r_mtr[1]  <= 1'b0;
        r_addr[1] <= '0;
        if (r_stall_count != '1) r_stall_count <= r_stall_count + CNT_W'(1);
      end else begin
        r_wren[1] <= r_wren[0];
        r_mtr[1]  <= r_mtr[0];
        r_addr[1] <= r_addr[0];
        if (i_flush) begin
          r_wren[0] <= 1'b0;
          r_mtr[0]  <= 1'b0;
          r_addr[0] <= '0;
        end else begin
          r_wren[0] <= w_in_wren;
          r_mtr[0]  <= w_in_mtr;
          r_addr[0] <= w_in_addr;
        end
      end
    end
  end

  assign o_front_hold         = i_load_stall & ~i_reset;
  assign o_ex_wren            = r_wren[0];
  assign o_ex_memtoreg        = r_mtr[0];
  assign o_ex_wraddr          = r_addr[0];
  assign o_firstwren          = r_wren[1];
  assign o_nextMemtoReg       = r_mtr[1];
  assign o_firstWriteRegister = r_addr[1];
  assign o_nextwren           = r_wren[2];
  assign o_MemtoReg           = r_mtr[2];
  assign o_nextWriteRegister  = r_addr[2];
  assign o_wren               = r_wren[3];
  assign o_prevMemtoReg       = r_mtr[3];
  assign o_writeRegister      = r_addr[3];
  assign o_stall_count        = r_stall_count;

endmodule
